// File: rtl/counter_v3_pkg.sv
// Shared definitions for the counter_v3 up/down counter.
//   DEFAULT_W   : default counter / load-value width
//   dir_e       : count direction as carried on up_down (DOWN=0, UP=1)
//   act_e       : the single action selected for a clock edge
//   decode_act  : rst > load > ce priority decode into one act_e
package counter_v3_pkg;

  localparam int unsigned DEFAULT_W = 4;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_e;

  typedef enum logic [2:0] {
    ACT_HOLD  = 3'd0,
    ACT_RESET = 3'd1,
    ACT_LOAD  = 3'd2,
    ACT_UP    = 3'd3,
    ACT_DOWN  = 3'd4
  } act_e;

  // Exactly one action per edge; reset beats load, load beats counting.
  function automatic act_e decode_act(input logic rst,
                                      input logic load,
                                      input logic ce,
                                      input logic up_down);
    act_e act;
    act = ACT_HOLD;
    if (rst) begin
      act = ACT_RESET;
    end else if (load) begin
      act = ACT_LOAD;
    end else if (ce) begin
      act = (dir_e'(up_down) == UP) ? ACT_UP : ACT_DOWN;
    end
    return act;
  endfunction

endpackage : counter_v3_pkg

// File: rtl/counter_v3_next.sv
// Pure combinational next-count computation for counter_v3.
// Ports:
//   rst, load, ce, up_down : control inputs for the coming edge
//   cnt                    : current count register value
//   load_val               : parallel-load value (unsigned, bit-for-bit)
//   cnt_nxt_c              : value the count register takes on the edge
module counter_v3_next
  import counter_v3_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         rst,
  input  logic         load,
  input  logic         ce,
  input  logic         up_down,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt_nxt_c
);

  act_e act_c;

  // Action select plus next value; W-bit arithmetic gives silent wrap.
  always_comb begin
    act_c     = decode_act(rst, load, ce, up_down);
    cnt_nxt_c = cnt;
    case (act_c)
      ACT_RESET: cnt_nxt_c = '0;
      ACT_LOAD:  cnt_nxt_c = load_val;
      ACT_UP:    cnt_nxt_c = cnt + W'(1);
      ACT_DOWN:  cnt_nxt_c = cnt - W'(1);
      default:   cnt_nxt_c = cnt;
    endcase
  end

endmodule : counter_v3_next

// File: rtl/counter_v3.sv
// Loadable W-bit up/down counter with synchronous active-high reset.
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset (highest priority)
//   ce       : count enable, one step per enabled edge
//   load     : synchronous parallel load (beats ce, needs no ce)
//   load_val : value loaded when load is accepted
//   up_down  : direction, 1 = increment, 0 = decrement
//   cnt      : current count, straight from the count register
module counter_v3
  import counter_v3_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up_down,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_nxt_c;

  counter_v3_next #(
    .W (W)
  ) u_next (
    .rst       (rst),
    .load      (load),
    .ce        (ce),
    .up_down   (up_down),
    .cnt       (cnt),
    .load_val  (load_val),
    .cnt_nxt_c (cnt_nxt_c)
  );

  // Single W-bit count register; reset is synchronous only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt_c;
    end
  end

endmodule : counter_v3

// File: tb/tb_counter_v3.sv
// Self-checking bench for counter_v3 (W=4): directed vector table,
// hand-written corner sequences, and randomized traffic against a
// modular-arithmetic reference model.
module tb_counter_v3;

  localparam int unsigned W   = 4;
  localparam int          MOD = 16;

  logic         clk;
  logic         rst;
  logic         ce;
  logic         load;
  logic [W-1:0] load_val;
  logic         up_down;
  logic [W-1:0] cnt;

  int checks;
  int failures;
  int model;

  typedef struct {
    logic         rst;
    logic         load;
    logic         ce;
    logic         ud;
    logic [W-1:0] lv;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[$];

  counter_v3 #(
    .W (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .load     (load),
    .load_val (load_val),
    .up_down  (up_down),
    .cnt      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic l, input logic c,
                              input logic u, input int lv, input int exp,
                              input string name);
    vec_t v;
    v.rst  = r;
    v.load = l;
    v.ce   = c;
    v.ud   = u;
    v.lv   = W'(lv);
    v.exp  = W'(exp);
    v.name = name;
    return v;
  endfunction

  // Reference: count value after one edge, from the priority rules.
  function automatic int ref_next(input int cur, input logic r, input logic l,
                                  input logic c, input logic u, input int lv);
    if (r) return 0;
    if (l) return lv % MOD;
    if (!c) return cur;
    if (u) return (cur + 1) % MOD;
    return (cur + MOD - 1) % MOD;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: cnt=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Drive at edge+1, advance one edge, leave time at next edge+1.
  task automatic step(input logic r, input logic l, input logic c,
                      input logic u, input logic [W-1:0] lv);
    rst      = r;
    load     = l;
    ce       = c;
    up_down  = u;
    load_val = lv;
    model    = ref_next(model, r, l, c, u, int'(lv));
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model    = 0;
    rst      = 1'b0;
    load     = 1'b0;
    ce       = 1'b0;
    up_down  = 1'b0;
    load_val = '0;

    // Reset / count / load priority / wrap / hold / direction / mid-run reset.
    vecs.push_back(mk(1, 0, 1, 1, 7, 0, "reset"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, "up1"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 2, "up2"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 3, "up3"));
    vecs.push_back(mk(0, 1, 1, 1, 12, 12, "load_c_ce"));
    vecs.push_back(mk(0, 1, 1, 0, 10, 10, "load_a_ce_down"));
    vecs.push_back(mk(0, 1, 0, 0, 15, 15, "load_f"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, "wrap_up"));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, "load_0"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 15, "wrap_down"));
    vecs.push_back(mk(0, 0, 0, 1, 3, 15, "hold_up"));
    vecs.push_back(mk(0, 0, 0, 0, 3, 15, "hold_down"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 14, "resume_down"));
    vecs.push_back(mk(0, 1, 0, 0, 5, 5, "load_5"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 6, "dir_up6"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 7, "dir_up7"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8, "dir_up8"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 7, "dir_dn7"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 6, "dir_dn6"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5, "dir_dn5"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4, "dir_dn4"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 3, "dir_dn3"));
    vecs.push_back(mk(1, 1, 1, 1, 9, 0, "midrun_reset_load"));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, "after_reset_up"));
    vecs.push_back(mk(0, 1, 0, 1, 8, 8, "load_8_no_ce"));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, "reset_idle"));

    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].ce, vecs[i].ud, vecs[i].lv);
      check(vecs[i].name, cnt, vecs[i].exp);
    end

    // No combinational path: input changes between edges leave cnt alone.
    step(0, 1, 0, 1, 4'd2);
    check("seq_load_2", cnt, 4'd2);
    rst      = 1'b1;
    load     = 1'b1;
    ce       = 1'b1;
    load_val = 4'd11;
    #2;
    check("seq_no_comb_path", cnt, 4'd2);
    step(0, 0, 1, 0, 4'd0);
    check("seq_down_from_2", cnt, 4'd1);
    step(0, 0, 1, 0, 4'd0);
    check("seq_down_to_0", cnt, 4'd0);
    step(0, 0, 1, 0, 4'd0);
    check("seq_down_wrap", cnt, 4'd15);

    // Long hold with direction toggling every cycle.
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, logic'(k[0]), 4'(k));
    end
    check("seq_long_hold", cnt, 4'd15);

    // Randomized traffic against the reference model.
    step(1, 0, 0, 0, 4'd0);
    check("rand_start_reset", cnt, 4'd0);
    for (int n = 0; n < 400; n++) begin
      logic r, l, c, u;
      logic [W-1:0] v;
      r = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 3) == 0);
      c = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      v = W'($urandom_range(0, MOD - 1));
      step(r, l, c, u, v);
      check("random", cnt, W'(model));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_counter_v3

// File: doc/counter_v3.md
COUNTER_V3 -- requirements
Module: counter_v3

Interface
REQ-001 Parameter W, default 4: counter and load-value width in bits; SHALL be legal for any W >= 1.
REQ-002 clk  input  1: sole clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1: synchronous, active-high reset, sampled on rising clk.
REQ-004 ce  input  1: count enable; high = count one step this cycle.
REQ-005 load  input  1: synchronous parallel-load request.
REQ-006 load_val  input  W: value written into the counter when load is accepted.
REQ-007 up_down  input  1: direction; 1 = increment, 0 = decrement.
REQ-008 cnt  output  W: current count, driven directly from the count register with no combinational path from any input.

Function
REQ-009 Priority per rising edge SHALL be: rst, then load, then ce; exactly one action per edge.
REQ-010 rst=1 SHALL set cnt to 0 on that edge, regardless of ce, load, load_val and up_down.
REQ-011 rst=0 with load=1 SHALL set cnt to load_val on that edge; load SHALL NOT require ce=1.
REQ-012 rst=0, load=0, ce=1, up_down=1 SHALL set cnt to (cnt + 1) mod 2^W.
REQ-013 rst=0, load=0, ce=1, up_down=0 SHALL set cnt to (cnt - 1) mod 2^W.
REQ-014 rst=0, load=0, ce=0 SHALL hold cnt unchanged, for any up_down value.
REQ-015 Latency: every action SHALL be visible on cnt one clock after the edge that samples the controlling inputs; there is no additional pipeline delay.
REQ-016 Wrap-around SHALL be silent: 2^W-1 up -> 0 and 0 down -> 2^W-1, with no saturation and no flag output.
REQ-017 load_val SHALL be treated as unsigned W bits; two's-complement patterns load bit-for-bit.
REQ-018 Simultaneous load=1 and ce=1 SHALL load load_val and SHALL NOT count in that cycle.
REQ-019 Changing up_down mid-sequence SHALL take effect on the next enabled edge without glitch or skipped value.

Reset
REQ-020 Reset SHALL be synchronous only; no asynchronous path SHALL exist, and cnt is undefined before the first edge with rst=1.
REQ-021 Reset asserted mid-count or coincident with load SHALL win; cnt = 0 on the next edge.
REQ-022 Deasserting rst SHALL make the counter follow REQ-011 to REQ-014 from the first edge on which rst=0.

Structure
REQ-023 Package counter_v3_pkg SHALL hold the default width constant (4) and a direction enumeration (DOWN=0, UP=1); counter_v3 SHALL use the package constant as the default of W.
REQ-024 Next-state selection (reset/load/up/down/hold) SHALL be coded as one combinational block feeding a single W-bit register.
REQ-025 Optional sub-module counter_v3_next (pure combinational next-value computation) is permitted; no other hierarchy.

Verification (W=4; inputs driven 0.5 ns after the rising edge, outputs sampled just before the edge)
REQ-026 Reset: rst=1 for one edge with cnt at any value -> cnt=0; then rst=0, ce=1, up_down=1 for 3 edges -> 1, 2, 3.
REQ-027 Load priority: load=1, load_val=4'hC, ce=1 -> cnt=C on the next edge, no increment; load=1, load_val=4'hA, ce=1, up_down=0 -> cnt=A.
REQ-028 Wrap: load F, then up for 1 edge -> 0; load 0, then down for 1 edge -> F.
REQ-029 Hold: ce=0 for 1 edge with up_down toggling -> cnt unchanged; ce=1 again -> counting resumes from the held value.
REQ-030 Direction change: from cnt=5, up 3 edges then down 5 edges -> 6, 7, 8, 7, 6, 5, 4, 3.
REQ-031 Mid-run reset: rst=1 asserted together with load=1 and ce=1 during counting -> cnt=0 on that edge.
